branch_cond_unit: RTL and testbench

//  Next-generation jump-condition block for the CPU branch path. Holds a flag

---
 rtl/branch_cond_unit_if.sv | 45 ++++
 rtl/branch_cond_unit.sv | 158 +++++++++++++++
 tb/tb_branch_cond_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_cond_unit_if.sv
// ---------------------------------------------------------------------------
// branch_cond_unit_if
//   Bundles the flag, branch-issue, prediction and resolution signals of
//   branch_cond_unit.
//   master : the issuing side (ALU flags, branch issue, fetch lookup)
//   slave  : the branch condition unit itself
//   Signals:
//     flag_we, flag_in[3:0]        ALU flag load ({C,Z,V,N})
//     br_valid, br_type, br_pc     branch issue
//     pred_pc / pred_taken         fetch-side prediction lookup
//     flags_q                      current flag register
//     res_valid/taken/pred/mispred resolution, one cycle after issue
//     stat_br / stat_mis           statistics counters
// ---------------------------------------------------------------------------
interface branch_cond_unit_if #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
);
  logic             flag_we;
  logic [3:0]       flag_in;
  logic             br_valid;
  logic [3:0]       br_type;
  logic [PC_W-1:0]  br_pc;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_taken;
  logic [3:0]       flags_q;
  logic             res_valid;
  logic             res_taken;
  logic             res_pred;
  logic             res_mispred;
  logic [CNT_W-1:0] stat_br;
  logic [CNT_W-1:0] stat_mis;

  modport master (
    output flag_we, flag_in, br_valid, br_type, br_pc, pred_pc,
    input  pred_taken, flags_q, res_valid, res_taken, res_pred, res_mispred,
           stat_br, stat_mis
  );

  modport slave (
    input  flag_we, flag_in, br_valid, br_type, br_pc, pred_pc,
    output pred_taken, flags_q, res_valid, res_taken, res_pred, res_mispred,
           stat_br, stat_mis
  );
endinterface

// File: rtl/branch_cond_unit.sv
// ---------------------------------------------------------------------------
// branch_cond_unit
//   Flag register (N,V,Z,C) with same-cycle ALU bypass, condition-code
//   resolution with one cycle of latency, and a PC-indexed bimodal predictor
//   built from 2-bit saturating counters.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset
//     bus  - branch_cond_unit_if.slave (flags, issue, lookup, resolution,
//            statistics)
//   Optional feature: define BCU_STATS_EN to build the saturating resolved-
//   branch / mispredict counters; otherwise stat_br/stat_mis read as zero.
//   Condition codes: 0 EQ, 1 CS, 2 HI, 3 LT, 4 GT, 5 AL, 6 NE, 7 CC, 8 GE,
//   9 LE, 10 LS, 11..15 NV.
// ---------------------------------------------------------------------------
module branch_cond_unit #(
  parameter int PC_W      = 16,
  parameter int BHT_IDX_W = 4,
  parameter int CNT_W     = 16
) (
  input logic          clk,
  input logic          rst,
  branch_cond_unit_if.slave bus
);

  localparam int DEPTH = 1 << BHT_IDX_W;

  logic [3:0]           flags_r;
  logic                 res_valid_r;
  logic                 res_taken_r;
  logic                 res_pred_r;
  logic                 res_mispred_r;
  logic [1:0]           bht_r [DEPTH];

  logic [3:0]           eval_flags_s;
  logic                 cond_s;
  logic                 is_cond_s;
  logic [BHT_IDX_W-1:0] issue_idx_s;
  logic [1:0]           issue_cnt_s;
  logic                 pred_s;
  logic                 unused_s;

  // Saturating 2-bit counter step: up when taken, down when not taken.
  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic t);
    logic [1:0] r;
    if (t) begin
      r = (c == 2'b11) ? 2'b11 : c + 2'b01;
    end else begin
      r = (c == 2'b00) ? 2'b00 : c - 2'b01;
    end
    return r;
  endfunction

  // Upper PC bits do not take part in the predictor index.
  assign unused_s = ^{bus.br_pc[PC_W-1:BHT_IDX_W], bus.pred_pc[PC_W-1:BHT_IDX_W]};

  // Flags used for evaluation: a flag write in the same cycle bypasses the register.
  assign eval_flags_s = bus.flag_we ? bus.flag_in : flags_r;
  assign issue_idx_s  = bus.br_pc[BHT_IDX_W-1:0];
  assign issue_cnt_s  = bht_r[issue_idx_s];

  // Condition decode; eval_flags_s = {C,Z,V,N}.
  always_comb begin
    cond_s = 1'b0;
    case (bus.br_type)
      4'd0:    cond_s = eval_flags_s[2];
      4'd1:    cond_s = eval_flags_s[3];
      4'd2:    cond_s = ~eval_flags_s[2] & ~eval_flags_s[3];
      4'd3:    cond_s = eval_flags_s[0] ^ eval_flags_s[1];
      4'd4:    cond_s = ~(eval_flags_s[0] ^ eval_flags_s[1]) & ~eval_flags_s[2];
      4'd5:    cond_s = 1'b1;
      4'd6:    cond_s = ~eval_flags_s[2];
      4'd7:    cond_s = ~eval_flags_s[3];
      4'd8:    cond_s = ~(eval_flags_s[0] ^ eval_flags_s[1]);
      4'd9:    cond_s = eval_flags_s[2] | (eval_flags_s[0] ^ eval_flags_s[1]);
      4'd10:   cond_s = eval_flags_s[2] | eval_flags_s[3];
      default: cond_s = 1'b0;
    endcase
  end

  // Only real conditional codes train the predictor; AL/NV are known in advance.
  always_comb begin
    is_cond_s = 1'b0;
    case (bus.br_type)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
      4'd6, 4'd7, 4'd8, 4'd9, 4'd10: is_cond_s = 1'b1;
      default:                       is_cond_s = 1'b0;
    endcase
  end

  // Prediction recorded at issue: counter MSB for conditionals, the known outcome otherwise.
  assign pred_s = is_cond_s ? issue_cnt_s[1] : cond_s;

  // Flag register, resolution pipeline stage and predictor table.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r       <= 4'b0000;
      res_valid_r   <= 1'b0;
      res_taken_r   <= 1'b0;
      res_pred_r    <= 1'b0;
      res_mispred_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        bht_r[i] <= 2'b01;
      end
    end else begin
      if (bus.flag_we) begin
        flags_r <= bus.flag_in;
      end
      res_valid_r <= bus.br_valid;
      if (bus.br_valid) begin
        res_taken_r   <= cond_s;
        res_pred_r    <= pred_s;
        res_mispred_r <= is_cond_s & (cond_s != issue_cnt_s[1]);
        if (is_cond_s) begin
          bht_r[issue_idx_s] <= cnt_next(issue_cnt_s, cond_s);
        end
      end
    end
  end

  assign bus.flags_q     = flags_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.res_taken   = res_taken_r;
  assign bus.res_pred    = res_pred_r;
  assign bus.res_mispred = res_mispred_r;
  // Lookup reads the pre-edge table, so a same-cycle update is not visible yet.
  assign bus.pred_taken  = bht_r[bus.pred_pc[BHT_IDX_W-1:0]][1];

`ifdef BCU_STATS_EN
  logic [CNT_W-1:0] stat_br_r;
  logic [CNT_W-1:0] stat_mis_r;
  logic             mis_s;

  assign mis_s = is_cond_s & (cond_s != issue_cnt_s[1]);

  // Statistics are counted at the issue edge so they line up with res_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_r  <= {CNT_W{1'b0}};
      stat_mis_r <= {CNT_W{1'b0}};
    end else if (bus.br_valid) begin
      if (stat_br_r != {CNT_W{1'b1}}) begin
        stat_br_r <= stat_br_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (mis_s && (stat_mis_r != {CNT_W{1'b1}})) begin
        stat_mis_r <= stat_mis_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.stat_br  = stat_br_r;
  assign bus.stat_mis = stat_mis_r;
`else
  assign bus.stat_br  = {CNT_W{1'b0}};
  assign bus.stat_mis = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_cond_unit
//   Directed testbench for branch_cond_unit. Inputs are driven on the falling
//   edge, outputs are checked 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_branch_cond_unit;

`ifdef BCU_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  branch_cond_unit_if #(.PC_W(16), .CNT_W(CNT_W)) bus ();

  branch_cond_unit #(.PC_W(16), .BHT_IDX_W(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference condition table; f = {C,Z,V,N}.
  function automatic logic cond_model(input int t, input logic [3:0] f);
    logic n, v, z, c;
    n = f[0]; v = f[1]; z = f[2]; c = f[3];
    if (t == 0)       return z;
    else if (t == 1)  return c;
    else if (t == 2)  return !z && !c;
    else if (t == 3)  return n != v;
    else if (t == 4)  return (n == v) && !z;
    else if (t == 5)  return 1'b1;
    else if (t == 6)  return !z;
    else if (t == 7)  return !c;
    else if (t == 8)  return n == v;
    else if (t == 9)  return z || (n != v);
    else if (t == 10) return z || c;
    else              return 1'b0;
  endfunction

  task automatic issue(input logic [3:0] t, input logic [15:0] pc,
                       input logic fwe, input logic [3:0] fin);
    @(negedge clk);
    bus.br_valid = 1'b1;
    bus.br_type  = t;
    bus.br_pc    = pc;
    bus.flag_we  = fwe;
    bus.flag_in  = fin;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.br_valid = 1'b0;
    bus.flag_we  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst          = 1'b1;
    bus.flag_we  = 1'b0;
    bus.flag_in  = 4'b0000;
    bus.br_valid = 1'b0;
    bus.br_type  = 4'd0;
    bus.br_pc    = 16'h0000;
    bus.pred_pc  = 16'h0000;
    repeat (2) @(posedge clk);

    // Branch and flag write during reset are dropped.
    issue(4'd6, 16'h0003, 1'b1, 4'b1111);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_flags", {28'd0, bus.flags_q}, 32'd0);
    chk("rst_res_taken", {31'd0, bus.res_taken}, 32'd0);
    chk("rst_res_pred", {31'd0, bus.res_pred}, 32'd0);
    chk("rst_res_mispred", {31'd0, bus.res_mispred}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus.pred_pc = 16'(i);
      #1;
      chk($sformatf("rst_pred_taken_%0d", i), {31'd0, bus.pred_taken}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.br_valid = 1'b0;
    bus.flag_we  = 1'b0;

    // EQ with Z=0: not taken, predicted not taken.
    issue(4'd0, 16'h0000, 1'b0, 4'b0000);
    chk("eq_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("eq_taken", {31'd0, bus.res_taken}, 32'd0);
    chk("eq_pred", {31'd0, bus.res_pred}, 32'd0);
    chk("eq_mispred", {31'd0, bus.res_mispred}, 32'd0);
    idle();
    chk("idle_valid", {31'd0, bus.res_valid}, 32'd0);

    // Flag bypass: Z written the same cycle as an EQ branch.
    issue(4'd0, 16'h0001, 1'b1, 4'b0100);
    chk("byp_taken", {31'd0, bus.res_taken}, 32'd1);
    chk("byp_pred", {31'd0, bus.res_pred}, 32'd0);
    chk("byp_mispred", {31'd0, bus.res_mispred}, 32'd1);
    chk("byp_flags", {28'd0, bus.flags_q}, 32'h4);

    // Three taken NE at pc 3: counter 01->10->11->11.
    issue(4'd6, 16'h0003, 1'b1, 4'b0000);
    chk("ne1_taken", {31'd0, bus.res_taken}, 32'd1);
    chk("ne1_mispred", {31'd0, bus.res_mispred}, 32'd1);
    issue(4'd6, 16'h0003, 1'b0, 4'b0000);
    chk("ne2_pred", {31'd0, bus.res_pred}, 32'd1);
    chk("ne2_mispred", {31'd0, bus.res_mispred}, 32'd0);
    issue(4'd6, 16'h0003, 1'b0, 4'b0000);
    chk("ne3_mispred", {31'd0, bus.res_mispred}, 32'd0);
    idle();
    bus.pred_pc = 16'h0013;
    #1;
    chk("alias_pred_13", {31'd0, bus.pred_taken}, 32'd1);
    bus.pred_pc = 16'h0001;
    #1;
    chk("pred_idx1", {31'd0, bus.pred_taken}, 32'd1);
    bus.pred_pc = 16'h0000;
    #1;
    chk("pred_idx0", {31'd0, bus.pred_taken}, 32'd0);

    // AL / NV: outcome known, no mispredict, no training at pc 5.
    bus.pred_pc = 16'h0005;
    for (int t = 5; t < 16; t++) begin
      if (t == 5 || t >= 11) begin
        issue(4'(t), 16'h0005, 1'b1, 4'(t));
        chk($sformatf("fix%0d_taken", t), {31'd0, bus.res_taken}, {31'd0, (t == 5)});
        chk($sformatf("fix%0d_pred", t), {31'd0, bus.res_pred}, {31'd0, (t == 5)});
        chk($sformatf("fix%0d_mispred", t), {31'd0, bus.res_mispred}, 32'd0);
        chk($sformatf("fix%0d_ptaken", t), {31'd0, bus.pred_taken}, 32'd0);
      end
    end

    // Full condition sweep, back-to-back, flags bypassed each cycle.
    for (int t = 0; t < 16; t++) begin
      for (int f = 0; f < 16; f++) begin
        issue(4'(t), 16'h0008, 1'b1, 4'(f));
        chk($sformatf("sweep_t%0d_f%0d", t, f), {31'd0, bus.res_taken},
            {31'd0, cond_model(t, 4'(f))});
      end
    end
    idle();
    chk("sweep_flags", {28'd0, bus.flags_q}, 32'hF);
    chk("sweep_hold_taken", {31'd0, bus.res_taken}, 32'd0);

    // Same-cycle lookup of the index being trained sees the old counter.
    @(negedge clk);
    bus.br_valid = 1'b1;
    bus.br_type  = 4'd6;
    bus.br_pc    = 16'h000A;
    bus.flag_we  = 1'b1;
    bus.flag_in  = 4'b0000;
    bus.pred_pc  = 16'h000A;
    #1;
    chk("rw_old", {31'd0, bus.pred_taken}, 32'd0);
    @(posedge clk);
    #1;
    chk("rw_new", {31'd0, bus.pred_taken}, 32'd1);

    // Reset the cycle after an issue: no resolution, counters back to 01.
    @(negedge clk);
    rst = 1'b1;
    bus.br_valid = 1'b0;
    bus.flag_we  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst2_pred_a", {31'd0, bus.pred_taken}, 32'd0);
    bus.pred_pc = 16'h0003;
    #1;
    chk("rst2_pred_3", {31'd0, bus.pred_taken}, 32'd0);
    chk("rst2_flags", {28'd0, bus.flags_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef BCU_STATS_EN
    // 4 mispredicting NE branches on fresh counters plus 6 AL branches.
    for (int p = 12; p < 16; p++) begin
      issue(4'd6, 16'(p), 1'b1, 4'b0000);
    end
    for (int k = 0; k < 6; k++) begin
      issue(4'd5, 16'h0000, 1'b0, 4'b0000);
    end
    chk("stat_br_10", 32'(bus.stat_br), 32'd10);
    chk("stat_mis_4", 32'(bus.stat_mis), 32'd4);
    for (int k = 0; k < 10; k++) begin
      issue(4'd5, 16'h0000, 1'b0, 4'b0000);
    end
    chk("stat_br_sat", 32'(bus.stat_br), 32'd15);
    chk("stat_mis_hold", 32'(bus.stat_mis), 32'd4);
`else
    issue(4'd6, 16'h000C, 1'b1, 4'b0000);
    chk("stat_br_off", 32'(bus.stat_br), 32'd0);
    chk("stat_mis_off", 32'(bus.stat_mis), 32'd0);
`endif
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
